// File: rtl/simd_pkg.sv
// Shared opcode encoding and pipeline-tag types for the SIMD PE array.
package simd_pkg;

  typedef enum logic [3:0] {
    OP_NOOP     = 4'd0,
    OP_ADD      = 4'd1,
    OP_SUB      = 4'd2,
    OP_MUL      = 4'd3,
    OP_DOTP     = 4'd4,
    OP_DOTP_CLR = 4'd5,
    OP_STOP     = 4'd8
  } opcode_t;

  // Valid/opcode tag travelling alongside the data through lane, tree and accumulator stages.
  typedef struct packed {
    logic    vld;
    opcode_t op;
  } pipe_t;

  function automatic int tree_depth(input int lanes);
    return $clog2(lanes);
  endfunction

  // Unlisted encodings collapse to NOOP so downstream stages only see legal opcodes.
  function automatic opcode_t decode_op(input logic [3:0] raw);
    case (raw)
      4'd1:    return OP_ADD;
      4'd2:    return OP_SUB;
      4'd3:    return OP_MUL;
      4'd4:    return OP_DOTP;
      4'd5:    return OP_DOTP_CLR;
      4'd8:    return OP_STOP;
      default: return OP_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One SIMD lane: registers a+b, a-b or the low half of a*b on an accepted instruction.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  opcode_t               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  logic [DATA_WIDTH-1:0] res_q, res_d;

  // Dot-product opcodes also produce the lane product; it feeds the adder tree.
  always_comb begin
    res_d = res_q;
    if (en_i) begin
      case (op_i)
        OP_ADD:                      res_d = a_i + b_i;
        OP_SUB:                      res_d = a_i - b_i;
        OP_MUL, OP_DOTP, OP_DOTP_CLR: res_d = a_i * b_i;
        default:                     res_d = res_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/simd_pe_array.sv
// N-lane SIMD PE array: lane-wise ADD/SUB/MUL plus a registered adder tree and
// running accumulator for dot products. STOP drains the pipeline and halts intake.
module simd_pe_array
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LANES        = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPCODE_WIDTH-1:0]     in_opcode,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        lane_valid,
  output logic [LANES*DATA_WIDTH-1:0] lane_out,
  output logic                        acc_valid,
  output logic [DATA_WIDTH-1:0]       acc_out,
  output logic                        stop
);

  localparam int TREE_LAT = tree_depth(LANES);
  localparam int DW       = DATA_WIDTH;

  // Handshake: an instruction is taken on a rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid and stays low after STOP.
  logic    in_ready_q;
  logic    accept;
  opcode_t in_op;

  assign accept   = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign in_op    = ((in_opcode >> 4) != '0) ? OP_NOOP : decode_op(in_opcode[3:0]);

  logic [DW-1:0] leaf [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane_alu #(.DATA_WIDTH(DW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (accept),
      .op_i  (in_op),
      .a_i   (in_a[g*DW +: DW]),
      .b_i   (in_b[g*DW +: DW]),
      .res_o (leaf[g])
    );
    assign lane_out[g*DW +: DW] = leaf[g];
  end

  // Heap-indexed tree: node i sums children 2i and 2i+1; indices >= LANES are the
  // lane results, so every internal node is one register level and node 1 is the root.
  logic [DW-1:0] node_q [1:LANES-1];
  logic [DW-1:0] all_n  [2:2*LANES-1];

  always_comb begin
    for (int i = 2; i < LANES; i++) all_n[i] = node_q[i];
    for (int i = 0; i < LANES; i++) all_n[LANES+i] = leaf[i];
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < LANES; i++) node_q[i] <= all_n[2*i] + all_n[2*i+1];
  end

  pipe_t pipe_q [0:TREE_LAT];
  pipe_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= TREE_LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= '{vld: accept, op: in_op};
      for (int k = 1; k <= TREE_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tail       = pipe_q[TREE_LAT];
  assign lane_valid = pipe_q[0].vld &&
                      (pipe_q[0].op == OP_ADD || pipe_q[0].op == OP_SUB || pipe_q[0].op == OP_MUL);

  logic [DW-1:0] acc_q;
  logic          acc_valid_q, stop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      stop_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      acc_valid_q <= tail.vld && (tail.op == OP_DOTP || tail.op == OP_DOTP_CLR);
      if (tail.vld && tail.op == OP_DOTP)     acc_q <= acc_q + node_q[1];
      if (tail.vld && tail.op == OP_DOTP_CLR) acc_q <= node_q[1];
      if (tail.vld && tail.op == OP_STOP)     stop_q <= 1'b1;
      if (accept && in_op == OP_STOP)         in_ready_q <= 1'b0;
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = acc_valid_q;
  assign stop      = stop_q;

endmodule

// File: tb/tb_simd_pe_array.sv
// Self-checking bench for simd_pe_array (4 lanes x 32 bits): directed cases plus a
// randomized opcode stream against a transaction-level reference model.
module tb_simd_pe_array;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int OW = 4;
  localparam int TL = 2;
  localparam int VW = DW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [OW-1:0] in_opcode = '0;
  logic [VW-1:0] in_a = '0;
  logic [VW-1:0] in_b = '0;
  logic          in_ready, lane_valid, acc_valid, stop;
  logic [VW-1:0] lane_out;
  logic [DW-1:0] acc_out;

  simd_pe_array #(.DATA_WIDTH(DW), .LANES(LN), .OPCODE_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .lane_valid (lane_valid),
    .lane_out   (lane_out),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .stop       (stop)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // scoreboard: expected results with the cycle index at which they must appear
  logic [VW-1:0] exp_lane_q[$];
  int            exp_lane_t[$];
  logic [DW-1:0] exp_acc_q[$];
  int            exp_acc_t[$];
  logic [DW-1:0] m_acc       = '0;
  logic [DW-1:0] exp_acc_out = '0;
  int            stop_at     = -1;
  int            ready_low_at = -1;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lane_of(input logic [VW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] vec(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                        input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Reference model: evaluates each accepted instruction as a whole transaction.
  always @(posedge clk) begin
    logic [VW-1:0] r;
    logic [DW-1:0] s, x, y;
    cyc++;
    if (rst) begin
      exp_lane_q.delete(); exp_lane_t.delete();
      exp_acc_q.delete();  exp_acc_t.delete();
      m_acc = '0; exp_acc_out = '0;
      stop_at = -1; ready_low_at = -1;
    end else if (in_valid && ready_low_at < 0) begin
      r = '0;
      s = '0;
      case (in_opcode)
        4'd1, 4'd2, 4'd3: begin
          for (int i = 0; i < LN; i++) begin
            x = lane_of(in_a, i);
            y = lane_of(in_b, i);
            if (in_opcode == 4'd1)      r[i*DW +: DW] = x + y;
            else if (in_opcode == 4'd2) r[i*DW +: DW] = x - y;
            else                        r[i*DW +: DW] = x * y;
          end
          exp_lane_q.push_back(r);
          exp_lane_t.push_back(cyc);
        end
        4'd4, 4'd5: begin
          for (int i = 0; i < LN; i++) begin
            x = lane_of(in_a, i);
            y = lane_of(in_b, i);
            s = s + x * y;
          end
          m_acc = (in_opcode == 4'd5) ? s : m_acc + s;
          exp_acc_q.push_back(m_acc);
          exp_acc_t.push_back(cyc + 1 + TL);
        end
        4'd8: begin
          stop_at      = cyc + 1 + TL;
          ready_low_at = cyc;
        end
        default: ;
      endcase
    end
  end

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge clk) begin
    bit lv, av;
    if (cyc > 0) begin
      while (exp_lane_t.size() > 0 && exp_lane_t[0] < cyc) begin
        void'(exp_lane_q.pop_front()); void'(exp_lane_t.pop_front());
      end
      while (exp_acc_t.size() > 0 && exp_acc_t[0] < cyc) begin
        void'(exp_acc_q.pop_front()); void'(exp_acc_t.pop_front());
      end
      lv = exp_lane_t.size() > 0 && exp_lane_t[0] == cyc;
      av = exp_acc_t.size() > 0 && exp_acc_t[0] == cyc;
      check("lane_valid", VW'(lane_valid), VW'(lv));
      if (lv) begin
        check("lane_out", lane_out, exp_lane_q[0]);
        void'(exp_lane_q.pop_front()); void'(exp_lane_t.pop_front());
      end
      check("acc_valid", VW'(acc_valid), VW'(av));
      if (av) begin
        exp_acc_out = exp_acc_q[0];
        void'(exp_acc_q.pop_front()); void'(exp_acc_t.pop_front());
      end
      check("acc_out", VW'(acc_out), VW'(exp_acc_out));
      check("in_ready", VW'(in_ready), VW'(!(ready_low_at >= 0 && cyc >= ready_low_at)));
      check("stop", VW'(stop), VW'(stop_at >= 0 && cyc >= stop_at));
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [OW-1:0] op,
                       input logic [VW-1:0] a, input logic [VW-1:0] b);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [VW-1:0] va, vb;

  initial begin
    do_reset(2);
    check("rst_lane_out", lane_out, '0);
    check("rst_in_ready", VW'(in_ready), VW'(1));

    // dot product: clear then accumulate
    va = vec(1, 2, 3, 4);
    vb = vec(5, 6, 7, 8);
    drive(1'b1, 4'd5, va, vb);
    drive(1'b1, 4'd4, va, vb);
    idle(6);
    check("dotp_acc140", VW'(acc_out), VW'(140));

    // lane-wise wrap cases
    drive(1'b1, 4'd1, vec(32'hFFFF_FFFF, 1, 2, 3), vec(1, 1, 1, 1));
    idle(2);
    check("add_wrap", lane_out, vec(0, 2, 3, 4));
    drive(1'b1, 4'd2, vec(0, 0, 0, 0), vec(1, 1, 1, 1));
    idle(2);
    check("sub_wrap", lane_out, vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    drive(1'b1, 4'd3, vec(32'h1_0000, 3, 32'hFFFF_FFFF, 7), vec(32'h1_0000, 5, 2, 9));
    idle(2);
    check("mul_low", lane_out, vec(0, 15, 32'hFFFF_FFFE, 63));

    // back-to-back DOTPs, bubble, STOP
    do_reset(1);
    drive(1'b1, 4'd4, va, vb);
    drive(1'b1, 4'd4, va, vb);
    idle(1);
    drive(1'b1, 4'd8, '0, '0);
    drive(1'b1, 4'd1, va, vb);
    idle(6);
    check("stop_acc", VW'(acc_out), VW'(140));
    check("stop_held", VW'(stop), VW'(1));
    check("stop_ready", VW'(in_ready), VW'(0));

    // reset one cycle after a DOTP accept
    do_reset(1);
    drive(1'b1, 4'd5, va, vb);
    idle(6);
    drive(1'b1, 4'd4, va, vb);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    check("midrst_acc", VW'(acc_out), VW'(0));
    check("midrst_ready", VW'(in_ready), VW'(1));
    check("midrst_stop", VW'(stop), VW'(0));

    // randomized mixed stream with occasional resets
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      logic [OW-1:0] op;
      if ($urandom_range(0, 1) == 1) op = OW'($urandom_range(1, 5));
      else begin
        op = OW'($urandom_range(0, 15));
        if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd0;
      end
      for (int i = 0; i < LN; i++) begin
        va[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 15));
        vb[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = op;
      in_a      = va;
      in_b      = vb;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);
    check("drain_lane", VW'(exp_lane_q.size()), '0);
    check("drain_acc", VW'(exp_acc_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_pe_array.md
Name: simd_pe_array

Overview:
- Parametrised N-lane SIMD processing-element array; next generation of the fixed 4-lane PE top.
- Accepts one vector instruction per cycle (opcode + two LANES-wide operand vectors).
- Produces lane-wise ADD/SUB/MUL results, or a pipelined adder-tree reduction with a running accumulator for dot products.
- Sits between the fetch unit and result writeback; a STOP opcode drains the pipeline and halts.

Parameters:
- DATA_WIDTH, 32, width of each lane operand/result and of the accumulator.
- LANES, 8, lane count; power of two, 2..64.
- OPCODE_WIDTH, 4, opcode field width.
- TREE_LAT, $clog2(LANES), derived (localparam): number of registered adder-tree stages.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  array accepts instruction (accept = in_valid & in_ready).
- in_opcode  in  OPCODE_WIDTH  instruction opcode.
- in_a  in  LANES*DATA_WIDTH  operand A vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_b  in  LANES*DATA_WIDTH  operand B vector, same packing.
- lane_valid  out  1  lane_out holds an ADD/SUB/MUL result.
- lane_out  out  LANES*DATA_WIDTH  lane-wise result vector.
- acc_valid  out  1  acc_out updated by DOTP/DOTP_CLR.
- acc_out  out  DATA_WIDTH  accumulator value.
- stop  out  1  sticky halt indication.

Behaviour:
- Opcodes: NOOP=0, ADD=1, SUB=2, MUL=3, DOTP=4, DOTP_CLR=5, STOP=8. Others are treated as NOOP.
- Reset values: in_ready=1, lane_valid=0, acc_valid=0, stop=0, lane_out=0, acc_out=0, all pipeline valid/opcode registers cleared.
- Reset mid-operation flushes every in-flight instruction; no output valid is produced for them.
- Lane stage: each lane registers f(a,b) one cycle after accept. Accept at cycle T gives lane_out/lane_valid at T+1.
  - lane_valid is a one-cycle pulse for ADD/SUB/MUL only.
  - For other opcodes lane_out may change but lane_valid=0.
- Arithmetic: all results modulo 2^DATA_WIDTH (two's-complement wrap). MUL keeps the low DATA_WIDTH bits of the product. No saturation, no carry output.
- Reduction: for DOTP/DOTP_CLR the lane stage computes products, then a binary adder tree of TREE_LAT registered levels sums them. Tree sum is valid at T+1+TREE_LAT.
- Accumulator: registered at T+2+TREE_LAT.
  - DOTP: acc = acc + sum.
  - DOTP_CLR: acc = sum.
  - acc_valid pulses one cycle at T+2+TREE_LAT.
  - acc_out holds its value otherwise.
- Opcode/valid pipeline: shift register of depth 2+TREE_LAT carrying opcode and valid alongside data. Tree and accumulator advance every cycle; there is no stall.
- Back-to-back DOTP every cycle: each accumulates exactly once, in issue order.
- A DOTP_CLR followed by DOTPs restarts accumulation from the DOTP_CLR sum.
- Not-accepted cycles (in_valid=0) insert a bubble. A bubble never modifies acc_out or pulses a valid.
- STOP:
  - in_ready drops the cycle after STOP is accepted and stays low until rst.
  - STOP travels the full pipeline; stop asserts at T+2+TREE_LAT and is sticky until rst.
  - All instructions accepted before STOP complete and emit their valids before or in the same cycle stop rises.
- in_valid while in_ready=0 is ignored.

Decomposition:
- Package simd_pkg: opcode enum (typedef opcode_t), opcode values, helper localparam for tree depth.
- Sub-module simd_lane_alu (one per lane, generate loop): registered ADD/SUB/MUL with opcode input.
- Adder tree and accumulator stay in simd_pe_array.

Test Plan (LANES=4, DATA_WIDTH=32):
- DOTP_CLR a={1,2,3,4}, b={5,6,7,8} -> acc_valid pulse at T+4, acc_out=70; then DOTP same operands next cycle -> acc_out=140 one cycle later.
- ADD a={0xFFFFFFFF,1,2,3}, b={1,1,1,1} -> lane_out={0,2,3,4} at T+1, lane_valid single pulse, acc_valid stays 0.
- SUB a={0,..}, b={1,..} -> lane0=0xFFFFFFFF; MUL 0x10000*0x10000 -> 0 (low bits only).
- Two back-to-back DOTPs (sum 70 each), bubble, then STOP -> acc_out 70 then 140 on consecutive cycles, in_ready=0 from cycle after STOP, stop=1 at STOP's T+4 and held.
- rst asserted one cycle after a DOTP accept -> no acc_valid pulse, acc_out=0, in_ready=1, stop=0 after reset.
- Random mixed opcode stream vs. reference model -> every lane/acc result matches in order, no extra or missing valid pulses.
